// File: rtl/adder_inc_pkg.sv
// Shared constants for the adder_inc incrementer slice.
// MAX_INC_WIDTH is the widest operand the incrementer supports. Instances
// elaborate-check their WIDTH against it.
package adder_inc_pkg;

  localparam int MAX_INC_WIDTH = 64;

endpackage

// File: rtl/prefix_and.sv
// Parallel-prefix AND network (Kogge-Stone style).
// Ports:
//   a : WIDTH-bit input vector
//   p : WIDTH-bit output, p[i] = &a[i:0] (inclusive prefix AND)
// The network has ceil(log2(WIDTH)) levels. At level l, each bit i >= 2^l
// combines with bit i-2^l. Each loop iteration maps to one rank of AND
// gates, so logic depth stays logarithmic instead of a ripple chain.
module prefix_and
  import adder_inc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] p
);

  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;

  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt;

  always_comb begin
    cur = a;
    nxt = a;
    for (int l = 0; l < LEVELS; l++) begin
      nxt = cur;
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << l)) begin
          nxt[i] = cur[i] & cur[i - (1 << l)];
        end
      end
      cur = nxt;
    end
    p = cur;
  end

endmodule

// File: rtl/adder_inc.sv
// Conditional incrementer with a registered copy of its result.
// Ports (the order is fixed so that existing positional instances stay valid):
//   a      : operand
//   out    : combinational (a + en) mod 2^WIDTH
//   en     : increment enable, acting as the carry-in
//   cout   : combinational carry-out. It is 1 only when en=1 and a is all ones.
//   clk    : clock, rising edge
//   rst    : synchronous active-low reset
//   out_q  : out registered on every edge (cleared to 0 in reset)
//   cout_q : cout registered on every edge (cleared to 0 in reset)
// There are no handshakes. The combinational path never sees clk or rst.
module adder_inc
  import adder_inc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] out,
  input  logic             en,
  output logic             cout,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out_q,
  output logic             cout_q
);

  if (WIDTH < 1 || WIDTH > MAX_INC_WIDTH) begin : g_width_check
    $error("adder_inc: WIDTH out of supported range");
  end

  // pre[i] is 1 when a[i:0] are all ones.
  logic [WIDTH-1:0] pre;
  logic [WIDTH-1:0] carry;

  prefix_and #(.WIDTH(WIDTH)) u_prefix_and (
    .a (a),
    .p (pre)
  );

  // The carry into bit i is en AND (all lower bits are ones). Bit 0 takes en directly.
  always_comb begin
    carry    = '0;
    carry[0] = en;
    for (int i = 1; i < WIDTH; i++) begin
      carry[i] = en & pre[i-1];
    end
  end

  assign out  = a ^ carry;
  assign cout = en & pre[WIDTH-1];

  // Capture on every edge with no enable. Reset takes priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      out_q  <= out;
      cout_q <= cout;
    end
  end

endmodule

// File: tb/tb_adder_inc.sv
// Directed and random checks of adder_inc at WIDTH = 34, 25 and 1.
module tb_adder_inc;

  logic clk;
  logic rst;

  logic [33:0] a34, out34, out34_q;
  logic        en34, cout34, cout34_q;
  logic [24:0] a25, out25, out25_q;
  logic        en25, cout25, cout25_q;
  logic [0:0]  a1, out1, out1_q;
  logic        en1, cout1, cout1_q;

  int checks = 0;
  int errors = 0;

  adder_inc #(.WIDTH(34)) dut34 (
    .a(a34), .out(out34), .en(en34), .cout(cout34),
    .clk(clk), .rst(rst), .out_q(out34_q), .cout_q(cout34_q)
  );

  adder_inc #(.WIDTH(25)) dut25 (
    .a(a25), .out(out25), .en(en25), .cout(cout25),
    .clk(clk), .rst(rst), .out_q(out25_q), .cout_q(cout25_q)
  );

  adder_inc #(.WIDTH(1)) dut1 (
    .a(a1), .out(out1), .en(en1), .cout(cout1),
    .clk(clk), .rst(rst), .out_q(out1_q), .cout_q(cout1_q)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Change the inputs at the falling edge, then let the combinational logic settle.
  task automatic drive34(input logic [33:0] av, input logic ev);
    @(negedge clk);
    a34 = av;
    en34 = ev;
    #1;
  endtask

  // Sample just after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [33:0] a_sv;
  logic [25:0] sum25;
  logic [24:0] ra;
  logic        re;

  initial begin
    rst = 1'b0;
    a34 = '0; en34 = 1'b0;
    a25 = '0; en25 = 1'b0;
    a1  = '0; en1  = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_out34_q", out34_q, 0);
    chk("rst_cout34_q", cout34_q, 0);
    chk("rst_out25_q", out25_q, 0);
    chk("rst_out1_q", out1_q, 0);
    chk("rst_cout1_q", cout1_q, 0);
    @(negedge clk);
    rst = 1'b1;

    // WIDTH=34: zero plus one, then the registered copy one edge later
    drive34(34'h0_0000_0000, 1'b1);
    chk("w34_zero_out", out34, 34'h0_0000_0001);
    chk("w34_zero_cout", cout34, 0);
    tick();
    chk("w34_zero_out_q", out34_q, 34'h0_0000_0001);
    chk("w34_zero_cout_q", cout34_q, 0);

    // A carry out of the low 32 bits into bit 32
    drive34(34'h0_FFFF_FFFF, 1'b1);
    chk("w34_mid_out", out34, 34'h1_0000_0000);
    chk("w34_mid_cout", cout34, 0);
    tick();
    chk("w34_mid_out_q", out34_q, 34'h1_0000_0000);

    // All ones wraps to zero with a carry-out
    drive34(34'h3_FFFF_FFFF, 1'b1);
    chk("w34_wrap_out", out34, 0);
    chk("w34_wrap_cout", cout34, 1);
    tick();
    chk("w34_wrap_out_q", out34_q, 0);
    chk("w34_wrap_cout_q", cout34_q, 1);

    // With en low, the operand passes straight through
    drive34(34'h3_FFFF_FFFF, 1'b0);
    chk("w34_pass_out", out34, 34'h3_FFFF_FFFF);
    chk("w34_pass_cout", cout34, 0);

    drive34(34'h2_AAAA_AAAB, 1'b1);
    chk("w34_alt_out", out34, 34'h2_AAAA_AAAC);
    drive34(34'h1_7FFF_FFFF, 1'b1);
    chk("w34_run_out", out34, 34'h1_8000_0000);
    drive34(34'h2_0000_FFFF, 1'b0);
    chk("w34_pass2_out", out34, 34'h2_0000_FFFF);

    // WIDTH=1
    a1 = 1'b1; en1 = 1'b1; #1;
    chk("w1_wrap_out", out1, 0);
    chk("w1_wrap_cout", cout1, 1);
    a1 = 1'b0; en1 = 1'b1; #1;
    chk("w1_inc_out", out1, 1);
    chk("w1_inc_cout", cout1, 0);
    a1 = 1'b1; en1 = 1'b0; #1;
    chk("w1_pass_out", out1, 1);
    chk("w1_pass_cout", cout1, 0);
    a1 = 1'b1; en1 = 1'b1;
    tick();
    chk("w1_out_q", out1_q, 0);
    chk("w1_cout_q", cout1_q, 1);

    // Reset in the middle of the stream. The registers hold nonzero values first.
    drive34(34'h3_FFFF_FFFF, 1'b1);
    tick();
    chk("mid_pre_cout_q", cout34_q, 1);
    @(negedge clk);
    rst = 1'b0;
    a34 = 34'h0_FFFF_FFFF;
    #1;
    chk("mid_comb_in_rst", out34, 34'h1_0000_0000);
    tick();
    chk("mid_rst_out_q", out34_q, 0);
    chk("mid_rst_cout_q", cout34_q, 0);
    @(negedge clk);
    rst = 1'b1;
    a34 = 34'h0_0000_0005;
    tick();
    chk("mid_resume_out_q", out34_q, 34'h0_0000_0006);
    chk("mid_resume_cout_q", cout34_q, 0);

    // WIDTH=25 random vectors, biased toward all ones to exercise the carry-out
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      ra = 25'($urandom());
      if ($urandom_range(0, 7) == 0) ra = '1;
      else if ($urandom_range(0, 7) == 0) ra = ra | 25'h0FF_FFFF;
      re = 1'($urandom_range(0, 1));
      a25 = ra;
      en25 = re;
      #1;
      sum25 = {1'b0, ra} + {25'd0, re};
      chk("w25_rand_out", out25, sum25[24:0]);
      chk("w25_rand_cout", cout25, sum25[25]);
      tick();
      chk("w25_rand_out_q", out25_q, sum25[24:0]);
      chk("w25_rand_cout_q", cout25_q, sum25[25]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
